// File: rtl/mcp4728_update_scheduler.sv
// mcp4728_update_scheduler
// Shares one MCP4728 I2C driver among four DAC chips. Requesters write a
// 4x4x12-bit shadow register file; a round-robin scheduler picks the next
// dirty chip, freezes a snapshot of its four channels and runs a level
// handshake (req -> busy -> idle) with the slow-clock driver, with a timeout
// that aborts and requeues the chip.
//
// Ports:
//   CLK100MHZ           system clock
//   reset               synchronous, active-low reset
//   enable              allow new transactions to start
//   wr_en/wr_chip/
//   wr_chan/wr_data     shadow register write port (one write per cycle)
//   drv_busy            driver busy level (driver clock domain)
//   drv_req             transaction request level to the driver
//   drv_dac0..drv_dac3  snapshot channel values
//   drv_dac_number      {1'b0, active_chip}, selects the LDAC line
//   active_chip         chip of the current or last transaction
//   dirty               per-chip pending-update flags
//   timeout_err         sticky timeout flag
//   update_count        completed transactions (wrapping)
module mcp4728_update_scheduler #(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 2000000,
  parameter int unsigned GAP_CYCLES     = 100
) (
  input  logic        CLK100MHZ,
  input  logic        reset,
  input  logic        enable,
  input  logic        wr_en,
  input  logic [1:0]  wr_chip,
  input  logic [1:0]  wr_chan,
  input  logic [11:0] wr_data,
  input  logic        drv_busy,
  output logic        drv_req,
  output logic [11:0] drv_dac0,
  output logic [11:0] drv_dac1,
  output logic [11:0] drv_dac2,
  output logic [11:0] drv_dac3,
  output logic [2:0]  drv_dac_number,
  output logic [1:0]  active_chip,
  output logic [3:0]  dirty,
  output logic        timeout_err,
  output logic [15:0] update_count
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned GW = $clog2(GAP_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_REQ,
    S_WAIT,
    S_GAP
  } state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   busy_s;
  logic [11:0]            shadow_q [4][4];
  logic [1:0]             ptr_q;
  logic [TW-1:0]          tmo_q;
  logic [GW-1:0]          gap_q;
  logic [3:0]             dirty_nxt;

  logic [1:0] sel_c;
  logic       sel_vld_c;
  logic       tmo_hit_c;
  logic       gap_end_c;
  logic       load_c;
  logic       done_c;
  logic       tmo_c;
  logic       req_drop_c;

  assign busy_s    = sync_q[SYNC_STAGES-1];
  assign tmo_hit_c = (tmo_q == TW'(TIMEOUT_CYCLES - 1));
  assign gap_end_c = (gap_q == GW'(GAP_CYCLES - 1));

  // Round-robin pick: first dirty chip after the pointer. Walking the
  // offsets from farthest to nearest lets the nearest one win.
  always_comb begin
    logic [1:0] cand;
    cand      = '0;
    sel_c     = ptr_q;
    sel_vld_c = 1'b0;
    for (int i = 4; i >= 1; i--) begin
      cand = ptr_q + 2'(i);
      if (dirty[cand]) begin
        sel_c     = cand;
        sel_vld_c = 1'b1;
      end
    end
  end

  // State register
  always_ff @(posedge CLK100MHZ) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state and control strobes
  always_comb begin
    state_d    = state_q;
    load_c     = 1'b0;
    done_c     = 1'b0;
    tmo_c      = 1'b0;
    req_drop_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (enable && (|dirty)) state_d = S_LOAD;
      end
      S_LOAD: begin
        if (sel_vld_c) begin
          load_c  = 1'b1;
          state_d = S_REQ;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REQ: begin
        // A handshake that makes progress wins over a coincident timeout.
        if (busy_s) begin
          req_drop_c = 1'b1;
          state_d    = S_WAIT;
        end else if (tmo_hit_c) begin
          tmo_c   = 1'b1;
          state_d = S_GAP;
        end
      end
      S_WAIT: begin
        if (!busy_s) begin
          done_c  = 1'b1;
          state_d = S_GAP;
        end else if (tmo_hit_c) begin
          tmo_c   = 1'b1;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (gap_end_c) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Dirty flags: a write (or timeout requeue) in the LOAD cycle beats the clear.
  always_comb begin
    dirty_nxt = dirty;
    if (load_c) dirty_nxt[sel_c]       = 1'b0;
    if (tmo_c)  dirty_nxt[active_chip] = 1'b1;
    if (wr_en)  dirty_nxt[wr_chip]     = 1'b1;
  end

  // Busy synchroniser, shadow file, snapshot and counters
  always_ff @(posedge CLK100MHZ) begin
    if (!reset) begin
      sync_q         <= '0;
      dirty          <= '0;
      ptr_q          <= 2'd3;
      tmo_q          <= '0;
      gap_q          <= '0;
      drv_req        <= 1'b0;
      drv_dac0       <= '0;
      drv_dac1       <= '0;
      drv_dac2       <= '0;
      drv_dac3       <= '0;
      drv_dac_number <= '0;
      active_chip    <= '0;
      timeout_err    <= 1'b0;
      update_count   <= '0;
      for (int c = 0; c < 4; c++) begin
        for (int k = 0; k < 4; k++) shadow_q[c][k] <= '0;
      end
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], drv_busy};
      dirty  <= dirty_nxt;

      if (wr_en) shadow_q[wr_chip][wr_chan] <= wr_data;

      // Snapshot uses the pre-write shadow contents on a same-cycle write.
      if (load_c) begin
        drv_dac0       <= shadow_q[sel_c][0];
        drv_dac1       <= shadow_q[sel_c][1];
        drv_dac2       <= shadow_q[sel_c][2];
        drv_dac3       <= shadow_q[sel_c][3];
        drv_dac_number <= {1'b0, sel_c};
        active_chip    <= sel_c;
        ptr_q          <= sel_c;
        drv_req        <= 1'b1;
      end else if (req_drop_c || tmo_c) begin
        drv_req <= 1'b0;
      end

      if (load_c)                                  tmo_q <= '0;
      else if (state_q == S_REQ || state_q == S_WAIT) tmo_q <= tmo_q + TW'(1);

      if (state_q == S_GAP) gap_q <= gap_q + GW'(1);
      else                  gap_q <= '0;

      if (tmo_c)  timeout_err  <= 1'b1;
      if (done_c) update_count <= update_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_mcp4728_update_scheduler.sv
module tb_mcp4728_update_scheduler;

  localparam int unsigned SYNC   = 2;
  localparam int unsigned TMO    = 1000;
  localparam int unsigned GAP    = 100;
  localparam int unsigned B_DLY  = 50;
  localparam int unsigned B_HOLD = 300;

  logic        CLK100MHZ = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic        wr_en = 1'b0;
  logic [1:0]  wr_chip = '0;
  logic [1:0]  wr_chan = '0;
  logic [11:0] wr_data = '0;
  logic        drv_busy;
  logic        drv_req;
  logic [11:0] drv_dac0, drv_dac1, drv_dac2, drv_dac3;
  logic [2:0]  drv_dac_number;
  logic [1:0]  active_chip;
  logic [3:0]  dirty;
  logic        timeout_err;
  logic [15:0] update_count;

  int total = 0;
  int bad = 0;
  bit drv_en = 1'b1;

  mcp4728_update_scheduler #(
    .SYNC_STAGES(SYNC), .TIMEOUT_CYCLES(TMO), .GAP_CYCLES(GAP)
  ) dut (
    .CLK100MHZ(CLK100MHZ), .reset(reset), .enable(enable),
    .wr_en(wr_en), .wr_chip(wr_chip), .wr_chan(wr_chan), .wr_data(wr_data),
    .drv_busy(drv_busy), .drv_req(drv_req),
    .drv_dac0(drv_dac0), .drv_dac1(drv_dac1), .drv_dac2(drv_dac2), .drv_dac3(drv_dac3),
    .drv_dac_number(drv_dac_number), .active_chip(active_chip), .dirty(dirty),
    .timeout_err(timeout_err), .update_count(update_count)
  );

  always #5 CLK100MHZ = ~CLK100MHZ;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK100MHZ);
    #1;
  endtask

  task automatic wr(input int chip, input int chan, input int data);
    tick();
    wr_en = 1'b1; wr_chip = 2'(chip); wr_chan = 2'(chan); wr_data = 12'(data);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic wait_req(input logic val, input int budget, input string tag);
    for (int i = 0; i < budget && drv_req !== val; i++) @(negedge CLK100MHZ);
    check(tag, 64'(drv_req), 64'(val));
  endtask

  task automatic wait_busy(input int budget);
    for (int i = 0; i < budget && drv_busy !== 1'b1; i++) @(negedge CLK100MHZ);
    check("wait_busy", 64'(drv_busy), 64'd1);
  endtask

  task automatic wait_idle();
    int quiet = 0;
    for (int i = 0; i < 30000 && quiet < 150; i++) begin
      @(negedge CLK100MHZ);
      if (!drv_req && !drv_busy && dirty == 4'd0) quiet++;
      else quiet = 0;
    end
    check("idle_reached", 64'(quiet >= 150), 64'd1);
  endtask

  // Driver model: busy rises B_DLY cycles after req is seen, stays B_HOLD.
  initial begin
    int phase = 0;
    int dcnt = 0;
    drv_busy = 1'b0;
    forever begin
      tick();
      if (!drv_en) begin
        drv_busy = 1'b0;
        phase = 0;
      end else begin
        case (phase)
          0: if (drv_req) begin dcnt = 0; phase = 1; end
          1: begin
            dcnt++;
            if (dcnt == B_DLY) begin drv_busy = 1'b1; dcnt = 0; phase = 2; end
          end
          default: begin
            dcnt++;
            if (dcnt == B_HOLD) begin drv_busy = 1'b0; phase = 0; end
          end
        endcase
      end
    end
  end

  // Reference model of the scheduler at transaction granularity.
  int       m_shadow [4][4];
  bit [3:0] m_dirty;
  int       m_ptr, m_active, m_count;
  bit       m_terr;
  int       order_q [$];

  initial begin
    logic       cap_wen, cap_rst, prev_req, have_prev, rise, fall;
    logic [1:0] cap_chip, cap_chan;
    logic [11:0] cap_data;
    logic [50:0] prev_snap, snap;
    int hi_run, lo_run, sel, c;
    prev_req = 0; have_prev = 0; prev_snap = '0; hi_run = 0; lo_run = 0;
    forever begin
      @(posedge CLK100MHZ);
      cap_wen = wr_en; cap_rst = reset; cap_chip = wr_chip; cap_chan = wr_chan; cap_data = wr_data;
      @(negedge CLK100MHZ);
      snap = {drv_dac_number, drv_dac3, drv_dac2, drv_dac1, drv_dac0};
      if (!cap_rst) begin
        for (int a = 0; a < 4; a++) for (int b = 0; b < 4; b++) m_shadow[a][b] = 0;
        m_dirty = '0; m_ptr = 3; m_active = 0; m_count = 0; m_terr = 0;
        prev_req = 0; have_prev = 0; prev_snap = '0; hi_run = 0; lo_run = 0;
      end else begin
        rise = drv_req && !prev_req;
        fall = !drv_req && prev_req;
        if (rise) begin
          sel = -1;
          for (int k = 1; k <= 4; k++) begin
            c = (m_ptr + k) % 4;
            if (sel < 0 && m_dirty[c]) sel = c;
          end
          check("load_had_dirty", 64'(sel >= 0), 64'd1);
          if (sel < 0) sel = 0;
          check("snap_number", 64'(drv_dac_number), 64'(sel));
          check("snap_dac0", 64'(drv_dac0), 64'(m_shadow[sel][0]));
          check("snap_dac1", 64'(drv_dac1), 64'(m_shadow[sel][1]));
          check("snap_dac2", 64'(drv_dac2), 64'(m_shadow[sel][2]));
          check("snap_dac3", 64'(drv_dac3), 64'(m_shadow[sel][3]));
          if (have_prev) check("gap_len", 64'(lo_run >= int'(GAP)), 64'd1);
          have_prev = 1;
          m_dirty[sel] = 1'b0; m_ptr = sel; m_active = sel;
          order_q.push_back(sel);
          hi_run = 0;
        end else begin
          check("snap_hold", 64'(snap), 64'(prev_snap));
        end
        if (fall) begin
          if (!drv_busy) begin
            check("timeout_len", 64'(hi_run), 64'(TMO));
            m_dirty[m_active] = 1'b1;
            m_terr = 1'b1;
          end else begin
            m_count++;
          end
          lo_run = 0;
        end
        if (drv_req) hi_run++; else lo_run++;
        if (cap_wen) begin
          m_shadow[cap_chip][cap_chan] = int'(cap_data);
          m_dirty[cap_chip] = 1'b1;
        end
        check("dirty", 64'(dirty), 64'(m_dirty));
        check("active_chip", 64'(active_chip), 64'(m_active));
        check("timeout_err", 64'(timeout_err), 64'(m_terr));
        prev_req = drv_req;
        prev_snap = snap;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    int max_req;

    // Reset values
    repeat (3) tick();
    @(negedge CLK100MHZ);
    check("rst_req", 64'(drv_req), 64'd0);
    check("rst_snap", 64'({drv_dac_number, drv_dac3, drv_dac2, drv_dac1, drv_dac0}), 64'd0);
    check("rst_count", 64'(update_count), 64'd0);
    check("rst_dirty", 64'(dirty), 64'd0);
    tick();
    reset = 1'b1;

    // Chip 2 full update
    wr(2, 0, 512); wr(2, 1, 1024); wr(2, 2, 2048); wr(2, 3, 4095);
    @(negedge CLK100MHZ);
    check("t1_dirty", 64'(dirty), 64'h4);
    check("t1_noreq", 64'(drv_req), 64'd0);
    tick();
    enable = 1'b1;
    wait_req(1'b1, 20, "t1_req_up");
    check("t1_num", 64'(drv_dac_number), 64'd2);
    check("t1_vals", 64'({drv_dac3, drv_dac2, drv_dac1, drv_dac0}),
          64'({12'd4095, 12'd2048, 12'd1024, 12'd512}));
    wait_req(1'b0, 200, "t1_req_down");
    check("t1_busy_at_drop", 64'(drv_busy), 64'd1);
    wait_idle();
    check("t1_count", 64'(update_count), 64'd1);
    check("t1_dirty0", 64'(dirty), 64'd0);

    // Write-to-request latency
    r = int'($urandom_range(0, 4095));
    tick();
    wr_en = 1'b1; wr_chip = 2'd0; wr_chan = 2'd0; wr_data = 12'(r);
    tick();
    wr_en = 1'b0;
    @(negedge CLK100MHZ);
    check("lat_dirty_p1", 64'(dirty), 64'h1);
    check("lat_req_p1", 64'(drv_req), 64'd0);
    @(negedge CLK100MHZ);
    check("lat_req_p2", 64'(drv_req), 64'd0);
    @(negedge CLK100MHZ);
    check("lat_req_p3", 64'(drv_req), 64'd1);
    check("lat_dac0", 64'(drv_dac0), 64'(r));
    wait_idle();
    check("lat_count", 64'(update_count), 64'd2);

    // Rewrite of the active chip during its handshake
    wr(1, 3, 100);
    wait_req(1'b1, 20, "rw_req_up");
    wait_busy(100);
    wr(1, 3, 200);
    @(negedge CLK100MHZ);
    check("rw_snap_held", 64'(drv_dac3), 64'd100);
    check("rw_redirty", 64'(dirty[1]), 64'd1);
    wait_idle();
    check("rw_second_val", 64'(drv_dac3), 64'd200);
    check("rw_count", 64'(update_count), 64'd4);

    // Write landing on the LOAD cycle of the same chip
    tick(); enable = 1'b0;
    wr(1, 0, 777);
    tick(); enable = 1'b1;
    tick();
    wr_en = 1'b1; wr_chip = 2'd1; wr_chan = 2'd0; wr_data = 12'd888;
    tick();
    wr_en = 1'b0;
    @(negedge CLK100MHZ);
    check("ld_req", 64'(drv_req), 64'd1);
    check("ld_old_val", 64'(drv_dac0), 64'd777);
    check("ld_dirty_kept", 64'(dirty[1]), 64'd1);
    wait_idle();
    check("ld_new_val", 64'(drv_dac0), 64'd888);
    check("ld_count", 64'(update_count), 64'd6);

    // Driver never answers: timeout, requeue, then retry succeeds
    drv_en = 1'b0;
    wr(3, 1, int'($urandom_range(0, 4095)));
    for (int i = 0; i < 3000 && timeout_err !== 1'b1; i++) @(negedge CLK100MHZ);
    check("to_flag", 64'(timeout_err), 64'd1);
    check("to_req_low", 64'(drv_req), 64'd0);
    check("to_requeue", 64'(dirty[3]), 64'd1);
    check("to_count_same", 64'(update_count), 64'd6);
    tick(); drv_en = 1'b1;
    wait_idle();
    check("to_retry_count", 64'(update_count), 64'd7);
    check("to_sticky", 64'(timeout_err), 64'd1);

    // Randomised writes against the model
    for (int n = 0; n < 40; n++) begin
      repeat ($urandom_range(0, 250)) tick();
      wr(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 4095)));
    end
    wait_idle();
    check("rnd_count", 64'(update_count), 64'(m_count));

    // Reset during WAIT
    wr(0, 2, int'($urandom_range(0, 4095)));
    wait_req(1'b1, 20, "rst_mid_up");
    wait_busy(100);
    wait_req(1'b0, 20, "rst_mid_wait");
    tick();
    reset = 1'b0; drv_en = 1'b0;
    tick();
    @(negedge CLK100MHZ);
    check("mrst_req", 64'(drv_req), 64'd0);
    check("mrst_snap", 64'({drv_dac_number, drv_dac3, drv_dac2, drv_dac1, drv_dac0}), 64'd0);
    check("mrst_active", 64'(active_chip), 64'd0);
    check("mrst_dirty", 64'(dirty), 64'd0);
    check("mrst_terr", 64'(timeout_err), 64'd0);
    check("mrst_count", 64'(update_count), 64'd0);
    tick();
    reset = 1'b1; drv_en = 1'b1; enable = 1'b0;

    // Disabled scheduler holds off; then fair order 0,1,2,3 after reset
    wr(3, 0, 30); wr(2, 0, 20); wr(1, 0, 10); wr(0, 0, 5);
    max_req = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge CLK100MHZ);
      if (drv_req) max_req = 1;
    end
    check("dis_noreq", 64'(max_req), 64'd0);
    check("dis_dirty", 64'(dirty), 64'hF);
    order_q.delete();
    tick(); enable = 1'b1;
    wait_idle();
    check("rr_len", 64'(order_q.size()), 64'd4);
    for (int i = 0; i < 4 && i < order_q.size(); i++) check("rr_order", 64'(order_q[i]), 64'(i));
    check("rr_count", 64'(update_count), 64'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
